// File: rtl/instr_mem_loader_if.sv
`default_nettype none
// ============================================================================
// instr_mem_loader_if : loader byte stream, fetch read port and load status
// Revision 1.0
// ============================================================================
interface instr_mem_loader_if #(
   parameter int ADDR_WIDTH = 12
);
   logic                  load_start;
   logic                  rx_valid;
   logic [7:0]            rx_data;
   logic                  load_busy;
   logic                  load_done;
   logic                  len_err;
   logic [ADDR_WIDTH:0]   words_loaded;
   logic [31:0]           imemraddr;
   logic [31:0]           imemrdata;

   modport master (
      output load_start, rx_valid, rx_data, imemraddr,
      input  load_busy, load_done, len_err, words_loaded, imemrdata
   );

   modport slave (
      input  load_start, rx_valid, rx_data, imemraddr,
      output load_busy, load_done, len_err, words_loaded, imemrdata
   );
endinterface
`default_nettype wire

// File: rtl/instr_mem_loader.sv
`default_nettype none
// ============================================================================
// instr_mem_loader : instruction memory with boot-time byte-stream loader
// Revision 1.0
// ============================================================================
module instr_mem_loader #(
   parameter int ADDR_WIDTH = 12
) (
   input  logic                clk,
   input  logic                rst,
   instr_mem_loader_if.slave   bus
);
   localparam int                  DEPTH = 1 << ADDR_WIDTH;
   localparam logic [31:0]         NOP   = 32'h0000_0013;
   localparam logic [ADDR_WIDTH:0] ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LEN  = 2'd1,
      DATA = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t                state, state_nx;
   logic [1:0]            byte_cnt;
   logic [23:0]           hold;
   logic [ADDR_WIDTH:0]   words_loaded;
   logic [ADDR_WIDTH:0]   remaining;
   logic                  len_err;
   logic [31:0]           rdata;
   logic                  wr_en;
   logic                  start;
   logic                  busy;
   logic                  accept;
   logic                  word_full;
   logic                  len_too_big;
   logic [31:0]           assembled;
   logic [ADDR_WIDTH-1:0] rd_idx;
   logic                  unused_addr;

   logic [31:0] mem [0:DEPTH-1];

   assign busy        = (state == LEN) || (state == DATA);
   assign accept      = bus.rx_valid && busy;
   assign word_full   = accept && (byte_cnt == 2'd3);
   assign assembled   = {bus.rx_data, hold};
   assign len_too_big = assembled > 32'(DEPTH);
   assign rd_idx      = bus.imemraddr[ADDR_WIDTH+1:2];
   assign unused_addr = ^{bus.imemraddr[31:ADDR_WIDTH+2], bus.imemraddr[1:0]};

   always_comb begin
      state_nx = state;
      wr_en    = 1'b0;
      start    = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (bus.load_start) begin
               state_nx = LEN;
               start    = 1'b1;
            end
         end
         LEN: begin
            if (word_full) begin
               if (assembled == 32'd0)
                  state_nx = DONE;
               else if (len_too_big)
                  state_nx = IDLE;
               else
                  state_nx = DATA;
            end
         end
         DATA: begin
            if (word_full) begin
               wr_en = 1'b1;
               if (remaining == ONE)
                  state_nx = DONE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         byte_cnt     <= 2'd0;
         hold         <= 24'd0;
         words_loaded <= '0;
         remaining    <= '0;
         len_err      <= 1'b0;
      end else begin
         state <= state_nx;
         if (start) begin
            byte_cnt     <= 2'd0;
            words_loaded <= '0;
            len_err      <= 1'b0;
         end else if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
               2'd0:    hold[7:0]   <= bus.rx_data;
               2'd1:    hold[15:8]  <= bus.rx_data;
               2'd2:    hold[23:16] <= bus.rx_data;
               default: ;
            endcase
            if (word_full && state == LEN) begin
               if (len_too_big)
                  len_err <= 1'b1;
               else
                  remaining <= assembled[ADDR_WIDTH:0];
            end
            if (wr_en) begin
               words_loaded <= words_loaded + ONE;
               remaining    <= remaining - ONE;
            end
         end
      end
   end

   // Writes are indexed by words_loaded, which never exceeds DEPTH-1 while writing
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[words_loaded[ADDR_WIDTH-1:0]] <= assembled;
   end

   // Non-blocking read of the same array gives read-before-write on collisions
   always_ff @(posedge clk) begin
      if (rst)
         rdata <= NOP;
      else
         rdata <= mem[rd_idx];
   end

   assign bus.load_busy    = busy;
   assign bus.load_done    = (state == DONE);
   assign bus.len_err      = len_err;
   assign bus.words_loaded = words_loaded;
   assign bus.imemrdata    = busy ? NOP : rdata;
endmodule
`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
`default_nettype none
// ============================================================================
// tb_instr_mem_loader : randomized loads and reads against a word-array model
// Revision 1.0
// ============================================================================
module tb_instr_mem_loader;
   localparam int          AW    = 12;
   localparam int          DEPTH = 1 << AW;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   instr_mem_loader_if #(.ADDR_WIDTH(AW)) ifc ();
   instr_mem_loader #(.ADDR_WIDTH(AW)) dut (.clk(clk), .rst(rst), .bus(ifc.slave));

   int          checks = 0;
   int          errors = 0;
   logic [31:0] model_mem [int];
   logic [31:0] exp_q [$];
   logic [31:0] words_q [$];
   logic        rd_req = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: a read requested before an edge is compared just after that edge
   initial begin
      logic took;
      logic [31:0] e;
      forever begin
         @(posedge clk);
         took = rd_req;
         #1;
         if (took) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL rdata_unexpected: got %h expected none", ifc.imemrdata);
            end else begin
               e = exp_q.pop_front();
               check("rdata", ifc.imemrdata, e);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

   task automatic step();
      @(negedge clk);
      ifc.rx_valid   = 1'b0;
      ifc.load_start = 1'b0;
      rd_req         = 1'b0;
   endtask

   task automatic issue_read(input logic [31:0] addr, input logic [31:0] exp);
      ifc.imemraddr = addr;
      rd_req        = 1'b1;
      exp_q.push_back(exp);
   endtask

   task automatic send_byte(input logic [7:0] b);
      ifc.rx_valid = 1'b1;
      ifc.rx_data  = b;
      step();
   endtask

   // Each byte is preceded by up to max_gap idle cycles carrying masked reads
   task automatic send_word(input logic [31:0] w, input int max_gap, input bit glitch);
      for (int i = 0; i < 4; i++) begin
         int g = $urandom_range(0, max_gap);
         repeat (g) begin
            issue_read($urandom, NOP);
            step();
         end
         if (glitch && i == 2) ifc.load_start = 1'b1;
         send_byte(w[8*i +: 8]);
      end
   endtask

   task automatic run_load(input logic [31:0] len, input int max_gap, input int glitch_word);
      logic exp_err;
      ifc.load_start = 1'b1;
      step();
      check("busy_rise", {31'd0, ifc.load_busy}, 32'd1);
      check("done_clr", {31'd0, ifc.load_done}, 32'd0);
      check("err_clr", {31'd0, ifc.len_err}, 32'd0);
      check("wl_clr", 32'(ifc.words_loaded), 32'd0);
      send_word(len, max_gap, 1'b0);
      exp_err = (len > DEPTH);
      if (!exp_err) begin
         for (int k = 0; k < int'(len); k++) begin
            send_word(words_q[k], max_gap, k == glitch_word);
            model_mem[k] = words_q[k];
         end
      end
      check("load_done", {31'd0, ifc.load_done}, {31'd0, !exp_err});
      check("busy_fall", {31'd0, ifc.load_busy}, 32'd0);
      check("len_err", {31'd0, ifc.len_err}, {31'd0, exp_err});
      check("words_loaded", 32'(ifc.words_loaded), exp_err ? 32'd0 : len);
   endtask

   task automatic read_back(input int n);
      for (int k = 0; k < n; k++) begin
         logic [31:0] a;
         a = ($urandom & 32'hFFFF_C000) | (32'(k) << 2) | 32'($urandom_range(0, 3));
         issue_read(a, model_mem[k]);
         step();
      end
      step();
   endtask

   initial begin
      logic [31:0] w_new;
      int n;
      ifc.load_start = 1'b0;
      ifc.rx_valid   = 1'b0;
      ifc.rx_data    = 8'd0;
      ifc.imemraddr  = 32'd0;
      repeat (3) step();
      check("rst_rdata", ifc.imemrdata, NOP);
      check("rst_busy", {31'd0, ifc.load_busy}, 32'd0);
      check("rst_done", {31'd0, ifc.load_done}, 32'd0);
      check("rst_err", {31'd0, ifc.len_err}, 32'd0);
      check("rst_wl", 32'(ifc.words_loaded), 32'd0);
      rst = 1'b0;
      step();

      // Directed two-word program, back-to-back bytes, then wrap read
      words_q = '{32'h0050_0093, 32'h0010_8113};
      run_load(32'd2, 0, -1);
      issue_read(32'h0, model_mem[0]); step();
      issue_read(32'h4, model_mem[1]); step();
      issue_read(32'h4000, model_mem[0]); step();
      step();

      // One word with 3-cycle gaps; gap reads must see NOP
      words_q = '{32'h0020_0113};
      run_load(32'd1, 3, -1);
      read_back(2);

      // Oversized length leaves memory untouched
      run_load(32'h0000_1001, 0, -1);
      repeat (5) send_byte(8'($urandom));
      check("err_idle_busy", {31'd0, ifc.load_busy}, 32'd0);
      read_back(2);

      // Zero-length load
      run_load(32'd0, 1, -1);

      // Randomized loads, one with a spurious load_start mid-data
      for (int r = 0; r < 4; r++) begin
         n = $urandom_range(1, 6);
         words_q.delete();
         for (int k = 0; k < n; k++) words_q.push_back($urandom);
         run_load(32'(n), 2, (r == 1) ? 0 : -1);
         read_back(n);
      end

      // Reset after 6 data bytes of a 3-word load
      words_q = '{$urandom, $urandom, $urandom};
      ifc.load_start = 1'b1;
      step();
      send_word(32'd3, 0, 1'b0);
      send_word(words_q[0], 0, 1'b0);
      model_mem[0] = words_q[0];
      send_byte(words_q[1][7:0]);
      send_byte(words_q[1][15:8]);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mid_rst_busy", {31'd0, ifc.load_busy}, 32'd0);
      check("mid_rst_done", {31'd0, ifc.load_done}, 32'd0);
      check("mid_rst_wl", 32'(ifc.words_loaded), 32'd0);
      repeat (4) send_byte(8'($urandom));
      check("post_rst_busy", {31'd0, ifc.load_busy}, 32'd0);
      check("post_rst_wl", 32'(ifc.words_loaded), 32'd0);
      read_back(1);

      // Read and write of word 0 on the same edge
      w_new = $urandom;
      ifc.load_start = 1'b1;
      step();
      send_word(32'd1, 0, 1'b0);
      for (int i = 0; i < 3; i++) send_byte(w_new[8*i +: 8]);
      issue_read(32'h0, model_mem[0]);
      send_byte(w_new[31:24]);
      model_mem[0] = w_new;
      check("raw_done", {31'd0, ifc.load_done}, 32'd1);
      issue_read(32'h0, model_mem[0]);
      step();
      step();

      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
